hazard_unit: RTL

- Consumer end of the pipeline control-signal interface.
- Takes the per-stage register-write, memory-to-register and branch control bits together with the register specifiers of the 5-stage MIPS pipeline.
- Produces the forwarding selects, the F/D/E/M stalls, the E-stage flush (flushE) and the W bubble.
- Adds a data-memory wait handshake FSM that freezes the pipeline on a slow memory, with timeout error detection.

---
 rtl/hazard_unit_pkg.sv | 37 +++
 rtl/hazard_unit_mem_wait_fsm.sv | 87 ++++++++
 rtl/hazard_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg
//   Shared constants and types for the hazard unit of the 5-stage MIPS pipeline:
//   forwarding select codes, the data-memory wait FSM state encoding, the
//   register-0 specifier and a helper that picks an E-stage forwarding source.
package hazard_unit_pkg;

    // E-stage forwarding mux selects
    localparam logic [1:0] FWD_RF = 2'b00;  // register file value
    localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
    localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

    // $zero is hardwired, so a match on it must never forward
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_ERR  = 2'd2
    } mem_state_t;

    // M beats W: the M-stage value is the younger write to the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] wr_m,
        input logic       regwr_m,
        input logic [4:0] wr_w,
        input logic       regwr_w
    );
        if (src != REG_ZERO && src == wr_m && regwr_m)
            return FWD_M;
        else if (src != REG_ZERO && src == wr_w && regwr_w)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_mem_wait_fsm.sv
// mem_wait_fsm
//   Data-memory wait handshake. A miss in IDLE stalls in the same cycle and
//   moves to WAIT; WAIT counts cycles until the memory signals ready or the
//   count reaches MEM_TIMEOUT, at which point the FSM parks in ERR (only a
//   reset leaves ERR) and raises a sticky error.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_req        M-stage load/store request
//   i_ready      memory completes the access this cycle
//   o_memstall   freeze the pipeline this cycle
//   o_mem_err    sticky timeout flag
module mem_wait_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_ready,
    output logic o_memstall,
    output logic o_mem_err
);
    import hazard_unit_pkg::*;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    mem_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_mem_err, w_err_nxt;
    logic             w_memstall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MS_IDLE;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mem_err <= w_err_nxt;
        end
    end

    // The cycle in which WAIT sees ready is the release cycle: the access
    // completes then, so the pipeline is allowed to advance in that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_mem_err;
        w_memstall  = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (i_req && !i_ready) begin
                    w_state_nxt = MS_WAIT;
                    w_cnt_nxt   = ONE_C;
                    w_memstall  = 1'b1;
                end
            end
            MS_WAIT: begin
                if (i_ready) begin
                    w_state_nxt = MS_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_memstall = 1'b1;
                    if (r_cnt == TIMEOUT_C) begin
                        w_state_nxt = MS_ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE_C;
                    end
                end
            end
            MS_ERR: begin
                w_memstall = 1'b1;
            end
            default: begin
                w_state_nxt = MS_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_memstall = w_memstall;
    assign o_mem_err  = r_mem_err;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Hazard detection and forwarding for the 5-stage MIPS pipeline, plus a
//   data-memory wait FSM that freezes the whole pipeline on a slow memory.
//   Optional feature macro: HAZARD_PERF_CNT_EN adds three 32-bit stall
//   counters (perf_lwstall, perf_brstall, perf_memstall).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rsD/rtD, rsE/rtE               source specifiers in D and E
//   writeregE/M/W                  destination specifier per stage
//   branchD, regwrite*, memtoreg*  stage control bits
//   dmem_reqM, dmem_readyM         data-memory handshake
//   stallF/D/E/M, flushE, flushW   pipeline register control
//   forwardAD/BD, forwardAE/BE     forwarding selects
//   mem_err                        sticky memory timeout flag
//   All outputs are forced to 0 while rst is high.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       branchD,
    input  logic       regwriteE,
    input  logic       memtoregE,
    input  logic       regwriteM,
    input  logic       memtoregM,
    input  logic       regwriteW,
    input  logic       dmem_reqM,
    input  logic       dmem_readyM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushE,
    output logic       flushW,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_lwstall,
    output logic [31:0] perf_brstall,
    output logic [31:0] perf_memstall
`endif
);
    import hazard_unit_pkg::*;

    logic w_memstall, w_mem_err;
    logic w_lwstall, w_brstall, w_hz;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_mem_wait_fsm (
        .clk       (clk),
        .rst       (rst),
        .i_req     (dmem_reqM),
        .i_ready   (dmem_readyM),
        .o_memstall(w_memstall),
        .o_mem_err (w_mem_err)
    );

    assign w_lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));
    // The branch compares in D, so it must wait for an E-stage ALU result or
    // an M-stage load; an M-stage ALU result is forwarded instead.
    assign w_brstall = branchD &&
        ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
         (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
    assign w_hz = w_lwstall || w_brstall;

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        mem_err   = 1'b0;
        if (!rst) begin
            forwardAE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
            forwardBE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
            forwardAD = (rsD != REG_ZERO) && (rsD == writeregM) && regwriteM;
            forwardBD = (rtD != REG_ZERO) && (rtD == writeregM) && regwriteM;
            mem_err   = w_mem_err;
            if (w_memstall) begin
                // D/E are frozen, so any hazard is simply re-evaluated after
                // release; W gets a bubble while M is held.
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else begin
                stallF = w_hz;
                stallD = w_hz;
                flushE = w_hz;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_lw, r_perf_br, r_perf_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_lw  <= '0;
            r_perf_br  <= '0;
            r_perf_mem <= '0;
        end else begin
            if (w_lwstall && !w_memstall)
                r_perf_lw <= r_perf_lw + 32'd1;
            if (w_brstall && !w_memstall && !w_lwstall)
                r_perf_br <= r_perf_br + 32'd1;
            if (w_memstall)
                r_perf_mem <= r_perf_mem + 32'd1;
        end
    end

    assign perf_lwstall  = r_perf_lw;
    assign perf_brstall  = r_perf_br;
    assign perf_memstall = r_perf_mem;
`endif

endmodule
